cpu_sequencer: RTL and testbench

Programmable instruction sequencer for the 4-bit accumulator datapath (mux, register, ALU). It replaces the free-running program counter and fixed ROM with an 8-entry writable program store, conditional branching on the ALU's zero/carry/overflow flags, a HALT instruction and a watchdog. Each cycle it drives `alu_sel`, `mux_sel` and `load` into the datapath.

---
 rtl/cpu_sequencer.sv | 148 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Programmable 8-entry instruction sequencer for the 4-bit accumulator datapath:
// EXEC/JMP/BR/HALT decode, flag-conditioned branches and an instruction watchdog.
module cpu_sequencer #(
  parameter int unsigned WDOG_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prog_we,
  input  logic [2:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       start,
  input  logic       stop,
  input  logic       zero_flag,
  input  logic       carry_out,
  input  logic       overflow_flag,
  output logic [1:0] alu_sel,
  output logic       mux_sel,
  output logic       load,
  output logic [2:0] pc,
  output logic [7:0] instr,
  output logic       busy,
  output logic       halted,
  output logic       timeout,
  output logic       prog_err,
  output logic [7:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_EXEC = 2'b00,
    OP_JMP  = 2'b01,
    OP_BR   = 2'b10,
    OP_HALT = 2'b11
  } opcode_e;

  localparam logic [7:0] HALT_WORD = 8'hC0;
  localparam logic [7:0] WDOG_CNT  = 8'(WDOG_LIMIT);
  localparam bit         WDOG_EN   = (WDOG_LIMIT != 0);

  state_e     state_q, state_d;
  logic [2:0] pc_q, pc_d;
  logic [7:0] count_q, count_d;
  logic       timeout_q, timeout_d;
  logic [7:0] mem_q [8];

  logic [7:0] word;
  opcode_e    op;
  logic [2:0] target;
  logic [2:0] pc_inc;
  logic       branch_taken;
  logic       wdog_fire;
  logic       execute;
  logic       mem_we;

  assign word   = mem_q[pc_q];
  assign op     = opcode_e'(word[7:6]);
  assign target = word[2:0];
  assign pc_inc = pc_q + 3'd1;

  // The watchdog fires on the cycle that would run instruction WDOG_LIMIT+1.
  assign wdog_fire = WDOG_EN && (state_q == S_RUN) && (count_q == WDOG_CNT);
  assign execute   = (state_q == S_RUN) && !stop && !wdog_fire;
  assign mem_we    = prog_we && (state_q != S_RUN);

  always_comb begin
    case (word[4:3])
      2'b00:   branch_taken = zero_flag;
      2'b01:   branch_taken = carry_out;
      2'b10:   branch_taken = overflow_flag;
      default: branch_taken = !zero_flag;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so that no path
    // through the case statements leaves it unassigned and infers a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    timeout_d = timeout_q;

    case (state_q)
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (wdog_fire) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
          case (op)
            OP_EXEC: pc_d = pc_inc;
            OP_JMP:  pc_d = target;
            OP_BR:   pc_d = branch_taken ? target : pc_inc;
            OP_HALT: state_d = S_HALT;
          endcase
        end
      end
      default: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d   = S_RUN;
          pc_d      = 3'd0;
          count_d   = 8'd0;
          timeout_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= 3'd0;
      count_q   <= 8'd0;
      timeout_q <= 1'b0;
      // NOTE: the program store is reset on purpose: a freshly reset sequencer
      // must see HALT everywhere, so it cannot be left as an unreset RAM.
      for (int i = 0; i < 8; i++) mem_q[i] <= HALT_WORD;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      if (mem_we) mem_q[prog_addr] <= prog_data;
    end
  end

  assign alu_sel     = (execute && op == OP_EXEC) ? word[3:2] : 2'b00;
  assign mux_sel     = execute && (op == OP_EXEC) && word[1];
  assign load        = execute && (op == OP_EXEC) && word[0];
  assign pc          = pc_q;
  assign instr       = word;
  assign busy        = (state_q == S_RUN);
  assign halted      = (state_q == S_HALT);
  assign timeout     = timeout_q;
  assign prog_err    = prog_we && (state_q == S_RUN);
  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: two instances (watchdog 5 and disabled) compared every
// cycle against a behavioural model, plus a decode table and directed sequences.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, prog_we, start, stop, zero_flag, carry_out, overflow_flag;
  logic [2:0] prog_addr;
  logic [7:0] prog_data;

  logic [1:0] alu_sel     [2];
  logic       mux_sel     [2];
  logic       load        [2];
  logic [2:0] pc          [2];
  logic [7:0] instr       [2];
  logic       busy        [2];
  logic       halted      [2];
  logic       timeout     [2];
  logic       prog_err    [2];
  logic [7:0] instr_count [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cpu_sequencer #(.WDOG_LIMIT(g == 0 ? 5 : 0)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .prog_we      (prog_we),
      .prog_addr    (prog_addr),
      .prog_data    (prog_data),
      .start        (start),
      .stop         (stop),
      .zero_flag    (zero_flag),
      .carry_out    (carry_out),
      .overflow_flag(overflow_flag),
      .alu_sel      (alu_sel[g]),
      .mux_sel      (mux_sel[g]),
      .load         (load[g]),
      .pc           (pc[g]),
      .instr        (instr[g]),
      .busy         (busy[g]),
      .halted       (halted[g]),
      .timeout      (timeout[g]),
      .prog_err     (prog_err[g]),
      .instr_count  (instr_count[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: running/halted flags, integer pc and count, array program.
  bit         m_run [2], m_halt [2], m_to [2];
  int         m_pc [2], m_cnt [2];
  logic [7:0] m_mem [2][8];
  bit         n_run [2], n_halt [2], n_to [2];
  int         n_pc [2], n_cnt [2];
  logic [7:0] n_mem [2][8];

  function automatic int lim_of(input int i);
    return (i == 0) ? 5 : 0;
  endfunction

  function automatic bit wdog_due(input int i);
    return lim_of(i) != 0 && m_cnt[i] == lim_of(i);
  endfunction

  task automatic model_reset_all();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_halt[i] = 0; m_to[i] = 0; m_pc[i] = 0; m_cnt[i] = 0;
      for (int a = 0; a < 8; a++) m_mem[i][a] = 8'hC0;
    end
  endtask

  task automatic model_next(input int i);
    logic [7:0] w;
    bit run, hlt, to, cond;
    int p, cnt;
    w = m_mem[i][m_pc[i]];
    run = m_run[i]; hlt = m_halt[i]; to = m_to[i]; p = m_pc[i]; cnt = m_cnt[i];
    for (int a = 0; a < 8; a++) n_mem[i][a] = m_mem[i][a];
    if (!rst) begin
      if (!run) begin
        if (prog_we) n_mem[i][int'(prog_addr)] = prog_data;
        if (stop) begin
          hlt = 0;
        end else if (start) begin
          run = 1; hlt = 0; p = 0; cnt = 0; to = 0;
        end
      end else if (stop) begin
        run = 0;
      end else if (wdog_due(i)) begin
        run = 0; hlt = 1; to = 1;
      end else begin
        cnt = (cnt < 255) ? cnt + 1 : 255;
        case (w[7:6])
          2'd0: p = (p + 1) % 8;
          2'd1: p = int'(w[2:0]);
          2'd2: begin
            case (w[4:3])
              2'd0:    cond = zero_flag;
              2'd1:    cond = carry_out;
              2'd2:    cond = overflow_flag;
              default: cond = !zero_flag;
            endcase
            p = cond ? int'(w[2:0]) : (p + 1) % 8;
          end
          default: begin run = 0; hlt = 1; end
        endcase
      end
    end
    n_run[i] = run; n_halt[i] = hlt; n_to[i] = to; n_pc[i] = p; n_cnt[i] = cnt;
  endtask

  task automatic model_commit();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = n_run[i]; m_halt[i] = n_halt[i]; m_to[i] = n_to[i];
      m_pc[i] = n_pc[i]; m_cnt[i] = n_cnt[i];
      for (int a = 0; a < 8; a++) m_mem[i][a] = n_mem[i][a];
    end
  endtask

  function automatic logic [26:0] model_outs(input int i);
    logic [7:0] w;
    logic [3:0] dp;
    logic       pe;
    w  = m_mem[i][m_pc[i]];
    dp = (m_run[i] && !stop && !wdog_due(i) && w[7:6] == 2'b00) ? w[3:0] : 4'h0;
    pe = m_run[i] && prog_we;
    return {dp, 3'(m_pc[i]), w, m_run[i], m_halt[i], m_to[i], pe, 8'(m_cnt[i])};
  endfunction

  function automatic logic [26:0] act_outs(input int i);
    return {alu_sel[i], mux_sel[i], load[i], pc[i], instr[i], busy[i], halted[i],
            timeout[i], prog_err[i], instr_count[i]};
  endfunction

  // One clock: compare both instances against the model, then advance both.
  task automatic tick();
    #2;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("outs_dut%0d", i), 32'(act_outs(i)), 32'(model_outs(i)));
      model_next(i);
    end
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic write_mem(input logic [2:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset_all();
    #1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [7:0] word;
    logic       zf, cf, of;
    logic [1:0] alu;
    logic       mux, ld;
    logic [2:0] pc_nxt;
    logic       hlt_nxt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{8'h0D, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 3'd1, 1'b0};
    vecs[1] = '{8'h36, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 3'd1, 1'b0};
    vecs[2] = '{8'h45, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'd5, 1'b0};
    vecs[3] = '{8'h8E, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd6, 1'b0};
    vecs[4] = '{8'h8E, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 3'd1, 1'b0};
    vecs[5] = '{8'h94, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 3'd4, 1'b0};
    vecs[6] = '{8'h9F, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'd7, 1'b0};
    vecs[7] = '{8'hBF, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1, 1'b0};
    vecs[8] = '{8'h83, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'd1, 1'b0};
    vecs[9] = '{8'hC0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1};

    rst = 1'b1; prog_we = 1'b0; prog_addr = 3'd0; prog_data = 8'h00;
    start = 1'b0; stop = 1'b0;
    zero_flag = 1'b0; carry_out = 1'b0; overflow_flag = 1'b0;
    model_reset_all();
    @(posedge clk);
    #1;
    do_reset();

    check("rst_pc", 32'(pc[0]), 32'd0);
    check("rst_instr", 32'(instr[0]), 32'hC0);
    check("rst_busy_halted", 32'({busy[0], halted[0], timeout[0], prog_err[0]}), 32'd0);
    check("rst_count", 32'(instr_count[0]), 32'd0);

    // Empty program: one HALT executes.
    do_start();
    check("empty_busy", 32'(busy[0]), 32'd1);
    check("empty_load", 32'(load[0]), 32'd0);
    tick();
    check("empty_halted", 32'(halted[0]), 32'd1);
    check("empty_count", 32'(instr_count[0]), 32'd1);

    // Load external, then accumulate ALU result, then HALT.
    write_mem(3'd0, 8'h01);
    write_mem(3'd1, 8'h03);
    write_mem(3'd2, 8'hC0);
    do_start();
    check("seq_c1", 32'({load[0], mux_sel[0]}), 32'b10);
    tick();
    check("seq_c2", 32'({load[0], mux_sel[0]}), 32'b11);
    tick();
    check("seq_c3_load", 32'(load[0]), 32'd0);
    tick();
    check("seq_halt_pc", 32'({halted[0], pc[0]}), 32'({1'b1, 3'd2}));
    check("seq_count", 32'(instr_count[0]), 32'd3);

    // BR on zero_flag: taken and not taken.
    write_mem(3'd0, 8'h0F);
    write_mem(3'd1, 8'h83);
    write_mem(3'd3, 8'hC0);
    do_start();
    tick();
    zero_flag = 1'b1;
    tick();
    check("br_taken_pc", 32'(pc[0]), 32'd3);
    zero_flag = 1'b0;
    tick();
    do_start();
    tick();
    tick();
    check("br_not_taken_pc", 32'(pc[0]), 32'd2);
    tick();

    // Single-instruction decode table.
    for (int v = 0; v < 10; v++) begin
      write_mem(3'd0, vecs[v].word);
      zero_flag = vecs[v].zf; carry_out = vecs[v].cf; overflow_flag = vecs[v].of;
      do_start();
      check($sformatf("tbl%0d_dp", v), 32'({alu_sel[0], mux_sel[0], load[0]}),
            32'({vecs[v].alu, vecs[v].mux, vecs[v].ld}));
      tick();
      check($sformatf("tbl%0d_next", v), 32'({halted[0], pc[0]}),
            32'({vecs[v].hlt_nxt, vecs[v].pc_nxt}));
      do_stop();
    end
    zero_flag = 1'b0; carry_out = 1'b0; overflow_flag = 1'b0;

    // Watchdog: JMP 0 forever, limit 5 on instance 0.
    write_mem(3'd0, 8'h40);
    do_start();
    run(5);
    check("wd_still_busy", 32'({busy[0], instr_count[0]}), 32'({1'b1, 8'd5}));
    tick();
    check("wd_halt_timeout", 32'({halted[0], timeout[0]}), 32'b11);
    check("wd_count", 32'(instr_count[0]), 32'd5);
    check("wd_disabled_runs", 32'({busy[1], instr_count[1]}), 32'({1'b1, 8'd6}));
    do_stop();
    do_start();
    check("wd_timeout_cleared", 32'(timeout[0]), 32'd0);

    // Rejected write while running.
    prog_we = 1'b1; prog_addr = 3'd4; prog_data = 8'h01;
    #1;
    check("perr_pulse", 32'(prog_err[0]), 32'd1);
    tick();
    prog_we = 1'b0;
    #1;
    check("perr_clear", 32'(prog_err[0]), 32'd0);
    do_stop();
    write_mem(3'd0, 8'h44);
    do_start();
    tick();
    check("perr_mem4_kept", 32'({pc[0], instr[0]}), 32'({3'd4, 8'hC0}));
    do_stop();

    // start and stop together in IDLE.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    #1;
    check("start_stop_idle", 32'({busy[0], halted[0]}), 32'd0);

    // Write and start in the same cycle: new word runs first.
    prog_we = 1'b1; prog_addr = 3'd0; prog_data = 8'h01; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    #1;
    check("we_start_instr", 32'({instr[0], load[0]}), 32'({8'h01, 1'b1}));
    do_stop();

    // Reset mid-run aborts at once.
    write_mem(3'd0, 8'h40);
    do_start();
    run(3);
    rst = 1'b1;
    model_reset_all();
    #1;
    check("midrst", 32'({busy[0], pc[0], instr[0], instr_count[0]}), 32'({1'b0, 3'd0, 8'hC0, 8'd0}));
    tick();
    rst = 1'b0;
    #1;

    // NOP loop: wrap and saturation on the instance without watchdog.
    for (int a = 0; a < 8; a++) write_mem(3'(a), 8'h00);
    do_start();
    run(8);
    check("nop_wrap", 32'({pc[1], instr_count[1]}), 32'({3'd0, 8'd8}));
    run(262);
    check("nop_saturate", 32'({busy[1], pc[1], instr_count[1]}), 32'({1'b1, 3'd6, 8'd255}));
    do_stop();
    check("nop_stop_hold", 32'({busy[1], pc[1]}), 32'({1'b0, 3'd6}));

    // Randomized traffic against the model.
    repeat (1500) begin
      rst = ($urandom_range(0, 199) == 0);
      if (rst) model_reset_all();
      prog_we       = ($urandom_range(0, 5) == 0);
      prog_addr     = 3'($urandom_range(0, 7));
      prog_data     = 8'($urandom);
      start         = ($urandom_range(0, 7) == 0);
      stop          = ($urandom_range(0, 15) == 0);
      zero_flag     = 1'($urandom_range(0, 1));
      carry_out     = 1'($urandom_range(0, 1));
      overflow_flag = 1'($urandom_range(0, 1));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
